pwm_capture: RTL
================

// Module: pwm_capture
// PURPOSE
// - Receive side of the 1-bit audio path. Captures a 1-bit PWM/PDM stream on pdm_in and
//   decimates it into PCM samples by counting ones over a fixed window of clk cycles.
// - Buffers samples in a small FIFO and hands them out on a valid/ready interface.
// - Sits on the divided audio clock domain and is the loopback/verification partner of the
//   PWM player.
// PARAMETERS
// - WIN    256  clk cycles per output sample; power of 2, >= 4
// - CW     9    ones-counter width = log2(WIN)+1; holds 0..WIN inclusive
// - DW     16   output sample width; DW >= CW
// - DEPTH  8    FIFO entries; power of 2
// PORTS
// - clk         in   1   single clock; all logic on posedge
// - rstn        in   1   asynchronous active-low reset
// - en          in   1   capture enable; level, synchronous to clk
// - pdm_in      in   1   1-bit audio stream; asynchronous, synchronised internally
// - sample_o    out  DW  FIFO head sample
// - valid_o     out  1   sample_o valid (FIFO not empty)
// - ready_i     in   1   consumer accepts sample_o when valid_o & ready_i
// - overflow_o  out  1   sticky: a sample was dropped because the FIFO was full
// - level_o     out  log2(DEPTH)+1   current FIFO occupancy
// BEHAVIOUR
// - Reset (rstn=0, async): state=IDLE, window counter=0, ones count=0, FIFO empty,
//   sample_o=0, valid_o=0, overflow_o=0, level_o=0, synchroniser flops=0.
// - pdm_in passes through a 2-flop synchroniser; "bit" below is the synchroniser output.
// - FSM:
//   - IDLE: counters held at 0. en=1 -> SETTLE, and overflow_o clears on that edge.
//   - SETTLE: runs one full WIN-cycle window and discards it (flushes the synchroniser and
//     the partial first window). At the end of the window -> RUN.
//   - RUN: each cycle, ones += bit and win_cnt += 1. On the cycle win_cnt==WIN-1, the bit
//     sampled that cycle is included, the total is pushed to the FIFO, and ones and win_cnt
//     restart at 0 on the same edge. No gap cycles between windows.
//   - en=0 in SETTLE or RUN -> IDLE on the next edge. The partial window is discarded and
//     no push occurs. FIFO contents are kept and can still be drained.
// - Sample format: ones count zero-extended to DW. Range 0..WIN; all-ones gives exactly WIN.
// - FIFO is show-ahead. sample_o and valid_o are registered and update one cycle after the
//   push edge when the FIFO was empty.
// - Pop happens on a clk edge with valid_o & ready_i. sample_o is undefined-stable (holds
//   its last value) while valid_o=0.
// - Full and push, no pop: the new sample is dropped, existing entries are untouched, and
//   overflow_o is set.
// - Full and push with pop on the same edge: both complete; no drop; level stays DEPTH.
// - Empty with push and ready_i=1: no pop that edge (valid_o was 0); the sample appears
//   next cycle.
// - Pointers wrap modulo DEPTH. level_o is maintained exactly, 0..DEPTH.
// - overflow_o is cleared only by reset or by the IDLE->SETTLE transition.
// - Reset asserted mid-window or mid-transfer: immediate return to reset values. The FIFO
//   is emptied.
// CONFIGURATION
// - Macro PWM_CAPTURE_SIGNED_EN.
//   - Defined: sample = ones - WIN/2 as two's complement, sign-extended to DW. Range
//     -WIN/2..+WIN/2; a 50% duty cycle gives 0.
//   - Undefined: unsigned zero-extended count as described above. No other behaviour
//     changes.
// TESTING
// - pdm_in=1 constant, en=1, ready_i=1 -> the first sample arrives about 2*WIN+3 cycles
//   after en. Every sample equals 0x0100 (0x0080 with SIGNED_EN).
// - pdm_in toggling every cycle -> every sample equals 0x0080 (0x0000 with SIGNED_EN).
//   overflow_o=0 throughout.
// - ready_i=0 for 10 windows with pdm_in=0 -> level_o saturates at 8 and overflow_o=1.
//   Raising ready_i then drains exactly 8 samples of 0x0000, then valid_o=0.
// - Full FIFO, with ready_i=1 on the push cycle -> no drop, level_o stays 8, overflow_o=0.
// - en dropped 100 cycles into a RUN window -> no sample from that window. After re-enable,
//   the next sample comes only after a SETTLE window plus a full window.
// - rstn pulsed low mid-window with 3 samples queued -> valid_o=0, level_o=0 and
//   overflow_o=0 immediately; sample_o=0.

Source files
------------

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture
// Purpose  : Decimates a 1-bit PDM/PWM stream into PCM samples (ones count per
//            WIN-cycle window) and queues them in a show-ahead valid/ready FIFO.
// Options  : PWM_CAPTURE_SIGNED_EN - samples become (ones - WIN/2), sign-extended.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_capture #(
    parameter int WIN   = 256,
    parameter int CW    = 9,
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       en,
    input  logic                       pdm_in,
    output logic [DW-1:0]              sample_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       overflow_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int c_ww = $clog2(WIN);
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_lw = c_aw + 1;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_settle = 2'd1;
    localparam logic [1:0] c_st_run    = 2'd2;

    logic              r_sync1;
    logic              r_sync2;
    logic [1:0]        r_state;
    logic [c_ww-1:0]   r_win_cnt;
    logic [CW-1:0]     r_ones;

    logic              w_win_end;
    logic              w_start;
    logic              w_push;
    logic [CW-1:0]     w_total;
    logic [DW-1:0]     w_sample;

    assign w_win_end = (r_win_cnt == c_ww'(WIN - 1));
    assign w_start   = (r_state == c_st_idle) && en;
    assign w_push    = (r_state == c_st_run) && en && w_win_end;
    // The bit seen on the closing cycle of the window is part of that window.
    assign w_total   = r_ones + CW'(r_sync2);

`ifdef PWM_CAPTURE_SIGNED_EN
    logic [CW-1:0] w_diff;
    assign w_diff   = w_total - CW'(WIN / 2);
    assign w_sample = DW'($signed(w_diff));
`else
    assign w_sample = DW'(w_total);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= c_st_idle;
            r_win_cnt <= '0;
            r_ones    <= '0;
        end else begin
            r_sync1 <= pdm_in;
            r_sync2 <= r_sync1;
            case (r_state)
                c_st_idle: begin
                    r_win_cnt <= '0;
                    r_ones    <= '0;
                    if (en) r_state <= c_st_settle;
                end
                c_st_settle: begin
                    if (!en) begin
                        r_state   <= c_st_idle;
                        r_win_cnt <= '0;
                    end else if (w_win_end) begin
                        r_state   <= c_st_run;
                        r_win_cnt <= '0;
                    end else begin
                        r_win_cnt <= r_win_cnt + c_ww'(1);
                    end
                    r_ones <= '0;
                end
                c_st_run: begin
                    if (!en) begin
                        r_state   <= c_st_idle;
                        r_win_cnt <= '0;
                        r_ones    <= '0;
                    end else if (w_win_end) begin
                        r_win_cnt <= '0;
                        r_ones    <= '0;
                    end else begin
                        r_win_cnt <= r_win_cnt + c_ww'(1);
                        r_ones    <= w_total;
                    end
                end
                default: begin
                    r_state   <= c_st_idle;
                    r_win_cnt <= '0;
                    r_ones    <= '0;
                end
            endcase
        end
    end

    logic [DW-1:0]     r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_lw-1:0]   r_level;
    logic [DW-1:0]     r_sample;
    logic              r_valid;
    logic              r_overflow;

    logic              w_pop;
    logic              w_full;
    logic              w_wr;
    logic              w_drop;
    logic [c_aw-1:0]   w_rd_ptr_nxt;
    logic [c_lw-1:0]   w_held;

    assign w_pop        = r_valid & ready_i;
    assign w_full       = (r_level == c_lw'(DEPTH));
    assign w_wr         = w_push & (~w_full | w_pop);
    assign w_drop       = w_push & w_full & ~w_pop;
    assign w_rd_ptr_nxt = r_rd_ptr + c_aw'(w_pop);
    // Entries already in memory after this edge's pop; a push this edge
    // only becomes visible at the head one cycle later.
    assign w_held       = r_level - c_lw'(w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_sample;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_sample   <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_aw'(w_wr);
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= r_level + c_lw'(w_wr) - c_lw'(w_pop);
            r_valid  <= (w_held != '0);
            if (w_held != '0) r_sample <= r_mem[w_rd_ptr_nxt];
            if (w_start)     r_overflow <= 1'b0;
            else if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign sample_o   = r_sample;
    assign valid_o    = r_valid;
    assign overflow_o = r_overflow;
    assign level_o    = r_level;

endmodule
`default_nettype wire
